// File: rtl/hilo_muldiv_ctrl_pkg.sv
// rtl/hilo_muldiv_ctrl_pkg.sv - op codes, FSM states and op decode helpers for hilo_muldiv_ctrl
package hilo_muldiv_ctrl_pkg;

    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_core.sv
// rtl/hilo_muldiv_ctrl_div_core.sv - restoring divider datapath, one quotient bit per step
module hilo_muldiv_ctrl_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH:0]   shifted, diff;

    // Partial remainder stays below the divisor, so one extra bit holds the shifted value.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO MULT/DIV sequencer; MUL_ITERATIVE_EN selects shift-add multiply
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall_req,
    output logic             busy,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic             from_core_q, from_core_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             core_load, core_step;
    logic [WIDTH-1:0] core_quo, core_rem, q_fix, r_fix;
    logic [2*WIDTH-1:0] prod_next, prod_fix;

    assign sign_a = md_is_signed(op) & src_a[WIDTH-1];
    assign sign_b = md_is_signed(op) & src_b[WIDTH-1];
    assign a_mag  = sign_a ? -src_a : src_a;
    assign b_mag  = sign_b ? -src_b : src_b;

    hilo_muldiv_ctrl_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (core_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    // Quotient negates on differing signs; remainder follows the dividend's sign.
    assign q_fix = neg_q_q ? -core_quo : core_quo;
    assign r_fix = neg_r_q ? -core_rem : core_rem;

`ifdef MUL_ITERATIVE_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;

    assign prod_next = prod_q + (b_mag_q[0] ? ({{WIDTH{1'b0}}, a_mag_q} << cnt_q) : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prod_q <= '0;
        else     prod_q <= prod_d;
    end
`else
    assign prod_next = {{WIDTH{1'b0}}, a_mag_q} * {{WIDTH{1'b0}}, b_mag_q};
`endif

    assign prod_fix = neg_q_q ? -prod_next : prod_next;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_mag_d     = a_mag_q;
        b_mag_d     = b_mag_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        from_core_d = from_core_q;
        core_load   = 1'b0;
        core_step   = 1'b0;
        stall_req   = 1'b0;
        hi_we       = 1'b0;
        lo_we       = 1'b0;
        hi_o        = '0;
        lo_o        = '0;
`ifdef MUL_ITERATIVE_EN
        prod_d      = prod_q;
`endif
        case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    stall_req = 1'b1;
                    cnt_d     = '0;
                    a_mag_d   = a_mag;
                    b_mag_d   = b_mag;
                    neg_q_d   = sign_a ^ sign_b;
                    neg_r_d   = sign_a;
                    if (md_is_div(op)) begin
                        if (src_b == '0) begin
                            res_hi_d    = src_a;
                            res_lo_d    = '1;
                            from_core_d = 1'b0;
                            state_d     = MD_DONE;
                        end else begin
                            core_load   = 1'b1;
                            from_core_d = 1'b1;
                            state_d     = MD_DIV;
                        end
                    end else begin
                        from_core_d = 1'b0;
`ifdef MUL_ITERATIVE_EN
                        prod_d      = '0;
`endif
                        state_d     = MD_MUL;
                    end
                end
            end
            MD_MUL: begin
                stall_req = 1'b1;
                if (flush) begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end else begin
`ifdef MUL_ITERATIVE_EN
                    prod_d  = prod_next;
                    b_mag_d = b_mag_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        {res_hi_d, res_lo_d} = prod_fix;
                        cnt_d   = '0;
                        state_d = MD_DONE;
                    end
`else
                    {res_hi_d, res_lo_d} = prod_fix;
                    state_d = MD_DONE;
`endif
                end
            end
            MD_DIV: begin
                stall_req = 1'b1;
                if (flush) begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end else begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        cnt_d   = '0;
                        state_d = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
                if (!flush) begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    hi_o  = from_core_q ? r_fix : res_hi_q;
                    lo_o  = from_core_q ? q_fix : res_lo_q;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            from_core_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_mag_q     <= a_mag_d;
            b_mag_q     <= b_mag_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            from_core_q <= from_core_d;
        end
    end

    assign busy = (state_q != MD_IDLE);

endmodule
